// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory bus arbiter
// Purpose: FSM state encoding, bus-mux select codes and grant bit indices
//          used by the arbiter top, its priority picker and the bus interface.
// Ports:   none (package).
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_TURN = 2'b10
    } fsm_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_D    = 2'b10;
    localparam logic [1:0] SEL_I    = 2'b11;

    // Bit positions inside the one-hot {icache, dcache, wb} grant vector.
    localparam int GNT_WB = 0;
    localparam int GNT_D  = 1;
    localparam int GNT_I  = 2;

    function automatic logic [1:0] grant_to_sel(input logic [2:0] grant);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (grant[GNT_I])       sel = SEL_I;
        else if (grant[GNT_D])  sel = SEL_D;
        else if (grant[GNT_WB]) sel = SEL_WB;
        return sel;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - request/grant/memory bundle of the memory bus arbiter
// Purpose: groups requester inputs and arbiter outputs into one bundle.
// Ports (signals):
//   wbreq, dreq, ireq      requests from write buffer, dcache, icache
//   drwb, irwb             cache direction, 1 = read
//   swc                    cache swap, 1 = icache is primary
//   memdone                external memory completion
//   grant[2:0]             one-hot {icache, dcache, wb}
//   state[1:0]             bus-mux select
//   memen, memrwb          memory enable, memory direction (0 = write)
//   donevec[2:0]           {idone, ddone, wbdone} completion pulses
//   timeout                one-cycle abort pulse
//   errcount[7:0]          saturating abort count
// Modports: slave = arbiter side, master = requester/memory side.
interface mem_bus_arbiter_if;

    logic       wbreq;
    logic       dreq;
    logic       ireq;
    logic       drwb;
    logic       irwb;
    logic       swc;
    logic       memdone;
    logic [2:0] grant;
    logic [1:0] state;
    logic       memen;
    logic       memrwb;
    logic [2:0] donevec;
    logic       timeout;
    logic [7:0] errcount;

    modport slave (
        input  wbreq, dreq, ireq, drwb, irwb, swc, memdone,
        output grant, state, memen, memrwb, donevec, timeout, errcount
    );

    modport master (
        output wbreq, dreq, ireq, drwb, irwb, swc, memdone,
        input  grant, state, memen, memrwb, donevec, timeout, errcount
    );

endinterface

// File: rtl/mem_bus_prio.sv
// rtl/mem_bus_prio.sv - combinational priority and anti-starvation picker
// Purpose: selects one requester from the eligible set.
//   Order is wb > primary > secondary, primary being dcache when swc=0 and
//   icache when swc=1. A saturated write-buffer streak hands the bus to a
//   pending read instead of the write buffer.
// Ports:
//   i_wb_elig, i_d_elig, i_i_elig  eligible requests
//   i_swc                          cache swap
//   i_wbstreak                     consecutive wb grants with a read pending
//   o_grant[2:0]                   one-hot {icache, dcache, wb}, 000 if none
module mem_bus_prio #(
    parameter int STARVE_LIMIT = 4,
    parameter int STREAK_W     = 3
) (
    input  logic                i_wb_elig,
    input  logic                i_d_elig,
    input  logic                i_i_elig,
    input  logic                i_swc,
    input  logic [STREAK_W-1:0] i_wbstreak,
    output logic [2:0]          o_grant
);
    import mem_pkg::*;

    logic       w_read_elig;
    logic       w_starved;
    logic [2:0] w_read_pick;

    assign w_read_elig = i_d_elig | i_i_elig;
    assign w_starved   = w_read_elig && (i_wbstreak == STREAK_W'(STARVE_LIMIT));

    always_comb begin
        w_read_pick = 3'b000;
        if (!i_swc) begin
            if (i_d_elig)      w_read_pick[GNT_D] = 1'b1;
            else if (i_i_elig) w_read_pick[GNT_I] = 1'b1;
        end else begin
            if (i_i_elig)      w_read_pick[GNT_I] = 1'b1;
            else if (i_d_elig) w_read_pick[GNT_D] = 1'b1;
        end
    end

    always_comb begin
        o_grant = 3'b000;
        if (i_wb_elig && !w_starved) o_grant[GNT_WB] = 1'b1;
        else                         o_grant = w_read_pick;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - three-master memory bus arbiter with watchdog
// Purpose: grants the memory bus to the write buffer, dcache or icache,
//   holds the grant until memdone or a watchdog abort, then idles the bus
//   for TURNAROUND cycles before arbitrating again.
// Ports:
//   ph1    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mem_bus_arbiter_if.slave (requests, memdone, grant/state/memen/
//          memrwb/donevec/timeout/errcount)
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4,
    parameter int TURNAROUND     = 1
) (
    input  logic               ph1,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    import mem_pkg::*;

    localparam int WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    fsm_t                r_fsm;
    fsm_t                w_fsm_nxt;
    logic [2:0]          r_grant;
    logic [1:0]          r_sel;
    logic                r_memen;
    logic                r_memrwb;
    logic                r_timeout;
    logic [7:0]          r_errcount;
    logic [STREAK_W-1:0] r_wbstreak;
    logic [WD_W-1:0]     r_wd;
    logic [1:0]          r_turn;

    logic                w_wb_elig;
    logic                w_d_elig;
    logic                w_i_elig;
    logic                w_read_elig;
    logic [2:0]          w_pick;
    logic                w_limit;
    logic                w_start;
    logic                w_done;
    logic                w_abort;

    // Cache writes never reach this arbiter; only cache reads compete.
    assign w_wb_elig   = bus.wbreq;
    assign w_d_elig    = bus.dreq & bus.drwb;
    assign w_i_elig    = bus.ireq & bus.irwb;
    assign w_read_elig = w_d_elig | w_i_elig;

    mem_bus_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .STREAK_W     (STREAK_W)
    ) u_prio (
        .i_wb_elig  (w_wb_elig),
        .i_d_elig   (w_d_elig),
        .i_i_elig   (w_i_elig),
        .i_swc      (bus.swc),
        .i_wbstreak (r_wbstreak),
        .o_grant    (w_pick)
    );

    // r_wd counts BUSY cycles already completed, so the limit is seen
    // during the TIMEOUT_CYCLES-th BUSY cycle.
    assign w_limit = (r_fsm == ST_BUSY) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) r_fsm <= ST_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_start   = 1'b0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (w_wb_elig || w_read_elig) begin
                    w_fsm_nxt = ST_BUSY;
                    w_start   = 1'b1;
                end
            end
            ST_BUSY: begin
                // memdone on the limit cycle counts as a normal completion.
                if (bus.memdone) begin
                    w_fsm_nxt = ST_TURN;
                    w_done    = 1'b1;
                end else if (w_limit) begin
                    w_fsm_nxt = ST_TURN;
                    w_abort   = 1'b1;
                end
            end
            ST_TURN: begin
                if (r_turn == 2'(TURNAROUND - 1)) w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_grant    <= 3'b000;
            r_sel      <= SEL_NONE;
            r_memen    <= 1'b0;
            r_memrwb   <= 1'b1;
            r_timeout  <= 1'b0;
            r_errcount <= 8'd0;
            r_wbstreak <= '0;
            r_wd       <= '0;
            r_turn     <= 2'd0;
        end else begin
            r_timeout <= w_abort;
            if (w_start) begin
                r_grant  <= w_pick;
                r_sel    <= grant_to_sel(w_pick);
                r_memen  <= 1'b1;
                r_memrwb <= ~w_pick[GNT_WB];
                r_wd     <= '0;
                // Streak only grows while a read is actually being held off.
                if (w_pick[GNT_WB] && w_read_elig) begin
                    if (r_wbstreak != STREAK_W'(STARVE_LIMIT))
                        r_wbstreak <= r_wbstreak + 1'b1;
                end else if (w_pick[GNT_D] || w_pick[GNT_I]) begin
                    r_wbstreak <= '0;
                end
            end else if (r_fsm == ST_BUSY) begin
                if (w_done || w_abort) begin
                    r_grant  <= 3'b000;
                    r_sel    <= SEL_NONE;
                    r_memen  <= 1'b0;
                    r_memrwb <= 1'b1;
                    r_turn   <= 2'd0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
                if (w_abort && (r_errcount != 8'hFF))
                    r_errcount <= r_errcount + 8'd1;
            end else if (r_fsm == ST_TURN) begin
                r_turn <= r_turn + 2'd1;
            end
        end
    end

    assign bus.grant    = r_grant;
    assign bus.state    = r_sel;
    assign bus.memen    = r_memen;
    assign bus.memrwb   = r_memrwb;
    assign bus.timeout  = r_timeout;
    assign bus.errcount = r_errcount;
    // The granted requester sees its done pulse on completion or abort.
    assign bus.donevec  = ((r_fsm == ST_BUSY) && (bus.memdone || w_limit)) ? r_grant : 3'b000;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int TIMEOUT_CYCLES = 255;
    localparam int STARVE_LIMIT   = 4;
    localparam int TURNAROUND     = 1;
    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_TURN = 2;

    logic ph1 = 1'b0;
    logic reset = 1'b0;
    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STARVE_LIMIT   (STARVE_LIMIT),
        .TURNAROUND     (TURNAROUND)
    ) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ph1 = ~ph1;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Transaction-level model: owner 1=wb, 2=dcache, 3=icache (0 none).
    int m_phase = P_IDLE;
    int m_owner = 0;
    int m_busy = 0;
    int m_turn_left = 0;
    int m_streak = 0;
    int m_errs = 0;
    int m_to = 0;

    logic [2:0] g_log[$];
    int         g_cyc[$];
    logic [2:0] d_log[$];
    int         to_cnt = 0;
    logic [2:0] prev_grant = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick();
        bit ok[4];
        int pri;
        int sec;
        int first_read;
        ok[0] = 1'b0;
        ok[1] = bus.wbreq;
        ok[2] = bus.dreq && bus.drwb;
        ok[3] = bus.ireq && bus.irwb;
        pri = bus.swc ? 3 : 2;
        sec = 5 - pri;
        first_read = 0;
        if (ok[pri])      first_read = pri;
        else if (ok[sec]) first_read = sec;
        if (ok[1] && !(m_streak == STARVE_LIMIT && first_read != 0)) return 1;
        return first_read;
    endfunction

    always @(posedge ph1) begin
        cyc++;
        if (!reset) begin
            m_phase = P_IDLE; m_owner = 0; m_busy = 0; m_turn_left = 0;
            m_streak = 0; m_errs = 0; m_to = 0;
        end else begin
            m_to = 0;
            case (m_phase)
                P_IDLE: begin
                    m_owner = model_pick();
                    if (m_owner != 0) begin
                        m_phase = P_BUSY;
                        m_busy = 0;
                        if (m_owner == 1 && ((bus.dreq && bus.drwb) || (bus.ireq && bus.irwb))) begin
                            if (m_streak < STARVE_LIMIT) m_streak++;
                        end else if (m_owner >= 2) begin
                            m_streak = 0;
                        end
                    end
                end
                P_BUSY: begin
                    m_busy++;
                    if (bus.memdone || m_busy == TIMEOUT_CYCLES) begin
                        if (!bus.memdone) begin
                            m_to = 1;
                            if (m_errs < 255) m_errs++;
                        end
                        m_phase = P_TURN;
                        m_turn_left = TURNAROUND;
                        m_owner = 0;
                    end
                end
                default: begin
                    m_turn_left--;
                    if (m_turn_left == 0) m_phase = P_IDLE;
                end
            endcase
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge ph1) begin
        logic [2:0] eg;
        logic [2:0] ed;
        if (!reset) begin
            chk("rst_grant", 32'(bus.grant), 32'd0);
            chk("rst_state", 32'(bus.state), 32'd0);
            chk("rst_memen", 32'(bus.memen), 32'd0);
            chk("rst_memrwb", 32'(bus.memrwb), 32'd1);
            chk("rst_donevec", 32'(bus.donevec), 32'd0);
            chk("rst_timeout", 32'(bus.timeout), 32'd0);
            chk("rst_errcount", 32'(bus.errcount), 32'd0);
        end else begin
            eg = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
            ed = (m_phase == P_BUSY && (bus.memdone || m_busy + 1 == TIMEOUT_CYCLES)) ? eg : 3'b000;
            chk("grant", 32'(bus.grant), 32'(eg));
            chk("state", 32'(bus.state), 32'(m_owner));
            chk("memen", 32'(bus.memen), 32'(m_phase == P_BUSY));
            chk("donevec", 32'(bus.donevec), 32'(ed));
            chk("timeout", 32'(bus.timeout), 32'(m_to));
            chk("errcount", 32'(bus.errcount), 32'(m_errs));
            if (m_phase == P_BUSY) chk("memrwb", 32'(bus.memrwb), 32'(m_owner != 1));
            if (bus.grant != 3'b000 && prev_grant == 3'b000) begin
                g_log.push_back(bus.grant);
                g_cyc.push_back(cyc);
            end
            if (bus.donevec != 3'b000) d_log.push_back(bus.donevec);
            if (bus.timeout) to_cnt++;
        end
        prev_grant = bus.grant;
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic wait_busy();
        int k;
        k = 0;
        while (m_phase != P_BUSY && k < 50) begin
            tick();
            k++;
        end
        chk("wait_busy_bound", 32'(m_phase == P_BUSY), 32'd1);
    endtask

    // memdone asserted during the n-th BUSY cycle.
    task automatic busy_done(input int n);
        wait_busy();
        repeat (n - 1) tick();
        bus.memdone = 1'b1;
        tick();
        bus.memdone = 1'b0;
    endtask

    task automatic clear_logs();
        g_log.delete();
        g_cyc.delete();
        d_log.delete();
    endtask

    task automatic idle_inputs();
        bus.wbreq = 1'b0; bus.dreq = 1'b0; bus.ireq = 1'b0;
        bus.drwb = 1'b0; bus.irwb = 1'b0; bus.swc = 1'b0; bus.memdone = 1'b0;
    endtask

    initial begin
        int cnt;
        int to0;
        logic saw_to;
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // dcache primary: dcache then icache, spacing 1 + 3 + 1.
        clear_logs();
        bus.swc = 1'b0; bus.dreq = 1'b1; bus.ireq = 1'b1; bus.drwb = 1'b1; bus.irwb = 1'b1;
        busy_done(3);
        bus.dreq = 1'b0;
        busy_done(3);
        idle_inputs();
        repeat (3) tick();
        chk("s1_ngrants", 32'(g_log.size()), 32'd2);
        if (g_log.size() == 2) begin
            chk("s1_first", 32'(g_log[0]), 32'b010);
            chk("s1_second", 32'(g_log[1]), 32'b100);
            chk("s1_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'd5);
        end
        chk("s1_ndone", 32'(d_log.size()), 32'd2);
        if (d_log.size() == 2) chk("s1_ddone", 32'(d_log[0]), 32'b010);

        // icache primary when swapped.
        clear_logs();
        bus.swc = 1'b1; bus.dreq = 1'b1; bus.ireq = 1'b1; bus.drwb = 1'b1; bus.irwb = 1'b1;
        wait_busy();
        chk("s2_state_i", 32'(bus.state), 32'b11);
        busy_done(3);
        bus.ireq = 1'b0;
        busy_done(3);
        idle_inputs();
        repeat (3) tick();
        chk("s2_ngrants", 32'(g_log.size()), 32'd2);
        if (g_log.size() == 2) begin
            chk("s2_first", 32'(g_log[0]), 32'b100);
            chk("s2_second", 32'(g_log[1]), 32'b010);
        end

        // Anti-starvation: four wb grants, then the pending dcache read.
        clear_logs();
        bus.wbreq = 1'b1; bus.dreq = 1'b1; bus.drwb = 1'b1;
        repeat (4) busy_done(2);
        chk("s3_streak_sat", 32'(m_streak), 32'd4);
        busy_done(2);
        idle_inputs();
        repeat (3) tick();
        chk("s3_streak_clr", 32'(m_streak), 32'd0);
        chk("s3_ngrants", 32'(g_log.size()), 32'd5);
        if (g_log.size() == 5) begin
            chk("s3_g0", 32'(g_log[0]), 32'b001);
            chk("s3_g3", 32'(g_log[3]), 32'b001);
            chk("s3_g4", 32'(g_log[4]), 32'b010);
        end

        // Watchdog abort after exactly TIMEOUT_CYCLES BUSY cycles.
        clear_logs();
        bus.wbreq = 1'b1;
        wait_busy();
        bus.wbreq = 1'b0;
        cnt = 0;
        saw_to = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.timeout) begin
                saw_to = 1'b1;
                break;
            end
            if (bus.memen) cnt++;
            tick();
        end
        chk("s4_timeout_seen", 32'(saw_to), 32'd1);
        chk("s4_busy_len", 32'(cnt), 32'd255);
        chk("s4_memen_after", 32'(bus.memen), 32'd0);
        chk("s4_errcount", 32'(bus.errcount), 32'd1);
        chk("s4_model_errs", 32'(m_errs), 32'd1);
        repeat (3) tick();
        chk("s4_ndone", 32'(d_log.size()), 32'd1);
        if (d_log.size() == 1) chk("s4_wbdone", 32'(d_log[0]), 32'b001);

        // Cache write alone is ignored.
        clear_logs();
        bus.dreq = 1'b1; bus.drwb = 1'b0;
        repeat (5) tick();
        chk("s5_no_grant", 32'(g_log.size()), 32'd0);
        chk("s5_memen", 32'(bus.memen), 32'd0);
        idle_inputs();

        // Reset mid-BUSY: immediate clear, no done pulse, resume after release.
        to0 = to_cnt;
        bus.wbreq = 1'b1;
        wait_busy();
        bus.wbreq = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("s5_rst_grant", 32'(bus.grant), 32'd0);
        chk("s5_rst_memen", 32'(bus.memen), 32'd0);
        chk("s5_rst_memrwb", 32'(bus.memrwb), 32'd1);
        chk("s5_rst_errcount", 32'(bus.errcount), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        bus.wbreq = 1'b1;
        tick();
        chk("s5_resume_grant", 32'(bus.grant), 32'b001);
        bus.wbreq = 1'b0;
        chk("s5_no_done", 32'(d_log.size()), 32'd0);
        bus.memdone = 1'b1;
        tick();
        bus.memdone = 1'b0;
        repeat (3) tick();
        chk("s5_no_timeout", 32'(to_cnt - to0), 32'd0);

        // memdone on the watchdog-limit cycle is a normal completion.
        clear_logs();
        to0 = to_cnt;
        bus.wbreq = 1'b1;
        busy_done(255);
        bus.wbreq = 1'b0;
        repeat (3) tick();
        chk("s6_no_timeout", 32'(to_cnt - to0), 32'd0);
        chk("s6_errcount", 32'(bus.errcount), 32'd0);
        chk("s6_ndone", 32'(d_log.size()), 32'd1);
        if (d_log.size() == 1) chk("s6_wbdone", 32'(d_log[0]), 32'b001);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got expired expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles without memdone before abort.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive write-buffer grants allowed while a read is pending.
REQ-003 Parameter TURNAROUND, default 1: idle bus cycles inserted after every transaction (range 1..3).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 ph1  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 wbreq  input  1  write buffer requests the bus.
REQ-008 dreq, ireq  input  1 each  data / instruction cache requests the bus.
REQ-009 drwb, irwb  input  1 each  cache direction; 1 = read, 0 = write.
REQ-010 swc  input  1  cache swap; 0 = normal, 1 = swapped.
REQ-011 memdone  input  1  external memory completion.
REQ-012 grant  output  3  one-hot {icache, dcache, wb}; 000 when no grant.
REQ-013 state  output  2  bus-mux select: 00 none, 01 wb, 10 dcache, 11 icache.
REQ-014 memen, memrwb  output  1 each  memory enable; memory direction (0 = write).
REQ-015 donevec  output  3  {idone, ddone, wbdone} completion pulses.
REQ-016 timeout  output  1  one-cycle pulse on an aborted transaction.
REQ-017 errcount  output  8  saturating count of timeouts.

Function
REQ-018 FSM states: IDLE, BUSY, TURN; state, grant, memen, memrwb, timeout and errcount are registered.
REQ-019 Eligibility: wbreq always; dreq only with drwb=1; ireq only with irwb=1; cache writes are ignored.
REQ-020 IDLE -> BUSY on the first edge with any eligible request; the grant is taken from that edge's inputs.
REQ-021 Priority: wb > primary > secondary; primary = dcache when swc=0 and icache when swc=1.
REQ-022 Anti-starvation: when wbstreak == STARVE_LIMIT and a read is eligible, that read wins over wb.
REQ-023 wbstreak increments on a wb grant issued while a read is eligible, saturates at STARVE_LIMIT, and clears on any read grant.
REQ-024 In BUSY: memen=1, memrwb=~grant[0], and grant/state are held constant regardless of request, rwb or swc changes.
REQ-025 donevec = memdone replicated onto the granted bit, only while in BUSY; memdone in IDLE or TURN is ignored.
REQ-026 BUSY -> TURN on memdone; grant, state and memen are 0 from the next cycle.
REQ-027 Watchdog: a counter clears on entering BUSY and increments each BUSY cycle.
REQ-028 When the watchdog reaches TIMEOUT_CYCLES without memdone: abort with a one-cycle timeout pulse, a donevec pulse on the granted bit, errcount+1 (saturating at 255), then -> TURN.
REQ-029 memdone in the same cycle as the watchdog limit is a normal completion: no timeout, no errcount increment.
REQ-030 TURN lasts exactly TURNAROUND cycles, then -> IDLE; requests are not sampled in TURN.
REQ-031 Minimum request spacing: grant-to-grant is 1 + BUSY length + TURNAROUND cycles.

Reset
REQ-032 Reset asserted: FSM = IDLE, grant=000, state=00, memen=0, memrwb=1, donevec=000, timeout=0, errcount=0, wbstreak=0, watchdog=0.
REQ-033 Reset mid-transaction aborts immediately, with no donevec and no timeout pulse; arbitration resumes on the first edge after release.

Structure
REQ-034 Shared package mem_pkg holds the FSM encodings, the state-select encodings (00/01/10/11) and the grant bit indices.
REQ-035 One sub-module, mem_bus_prio, is the combinational priority and anti-starvation picker (eligibility, swc, wbstreak in; one-hot grant out).
REQ-036 The watchdog, turnaround and errcount counters live in mem_bus_arbiter.

Verification
REQ-037 swc=0, dreq=ireq=1 with both rwb=1, memdone after 3 cycles -> grant=010, state=10, memrwb=1, ddone pulse, TURN 1 cycle, then grant=100.
REQ-038 swc=1, same stimulus -> icache granted first (state=11), then dcache.
REQ-039 wbreq held high, dreq=1 with drwb=1, memdone every 2 cycles -> four wb grants, then a dcache grant, then wbstreak=0.
REQ-040 wbreq=1, memdone never asserted -> timeout pulse after exactly 255 BUSY cycles, wbdone pulse, errcount=1, memen=0 in the following cycle.
REQ-041 dreq=1 with drwb=0 and no other request -> stays IDLE, memen=0; reset asserted mid-BUSY -> all outputs at reset values, no done pulse.
REQ-042 memdone coincident with the watchdog limit -> normal done, timeout=0, errcount unchanged.
